// File: rtl/time_keeper.sv
// time_keeper: divides the board clock into a one-second strobe and keeps the
// time of day both as seconds-since-midnight and as hour/minute/second fields.
// The two representations are updated together on every edge so they can
// never disagree, even for one cycle.
module time_keeper #(
    parameter int CLK_HZ  = 100000000,
    parameter int DAY_SEC = 86400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        load,
    input  logic [16:0] load_sec,
    input  logic        inc_hour,
    input  logic        inc_min,
    output logic        sec_tick,
    output logic [16:0] cur_sec,
    output logic [4:0]  hour,
    output logic [5:0]  minute,
    output logic [5:0]  second
);

    localparam int            PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] P_TC   = PW'(CLK_HZ - 1);
    localparam logic [16:0]   DAY_N  = 17'(DAY_SEC);
    localparam logic [16:0]   DAY_M1 = 17'(DAY_SEC - 1);

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic [16:0]   r_cur;
    logic [4:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;

    logic          w_term;
    logic [16:0]   w_ld;

    // Terminal-count detect and range reduction of the load value
    // (one subtraction is enough for any 17-bit input).
    always_comb begin
        w_term = run && (r_presc == P_TC);
        w_ld   = (load_sec >= DAY_N) ? load_sec - DAY_N : load_sec;
    end

    // Prescaler, tick strobe and time-of-day registers; priority is
    // load > inc_hour > inc_min > tick advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_cur   <= '0;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
        end else begin
            // A tick that coincides with an adjust still strobes and restarts
            // the prescaler; only its advance of the time is dropped.
            r_tick <= w_term;
            if (load || w_term)
                r_presc <= '0;
            else if (run)
                r_presc <= r_presc + 1'b1;

            if (load) begin
                r_cur  <= w_ld;
                r_hour <= 5'(w_ld / 17'd3600);
                r_min  <= 6'((w_ld % 17'd3600) / 17'd60);
                r_sec  <= 6'(w_ld % 17'd60);
            end else if (inc_hour) begin
                if (r_hour == 5'd23) begin
                    r_hour <= '0;
                    r_cur  <= r_cur - 17'd82800;
                end else begin
                    r_hour <= r_hour + 5'd1;
                    r_cur  <= r_cur + 17'd3600;
                end
            end else if (inc_min) begin
                if (r_min == 6'd59) begin
                    r_min <= '0;
                    r_cur <= r_cur - 17'd3540;
                end else begin
                    r_min <= r_min + 6'd1;
                    r_cur <= r_cur + 17'd60;
                end
            end else if (w_term) begin
                r_cur <= (r_cur == DAY_M1) ? '0 : r_cur + 17'd1;
                if (r_sec == 6'd59) begin
                    r_sec <= '0;
                    if (r_min == 6'd59) begin
                        r_min  <= '0;
                        r_hour <= (r_hour == 5'd23) ? '0 : r_hour + 5'd1;
                    end else begin
                        r_min <= r_min + 6'd1;
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end
        end
    end

    assign sec_tick = r_tick;
    assign cur_sec  = r_cur;
    assign hour     = r_hour;
    assign minute   = r_min;
    assign second   = r_sec;

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
Time-of-day source for the clock. It divides the board clock into a one-second strobe and keeps the current time as seconds-since-midnight, 0..86399. It also keeps the hour/minute/second fields in step. Its cur_sec and sec_tick outputs feed the alarm stage, whose cur_sec input is 17 bits. The time is loaded or adjusted from the debounced user-input stage.

Parameters:
CLK_HZ, 100000000, board clock frequency; the prescaler terminal count is CLK_HZ-1.
DAY_SEC, 86400, seconds per day; cur_sec wraps at DAY_SEC-1.

Ports:
clk  input  1  board clock; the single clock domain.
rst_n  input  1  synchronous reset, active-low.
run  input  1  1 = time advances; 0 = paused (the prescaler holds its count).
load  input  1  one-cycle pulse: replace the time with load_sec.
load_sec  input  17  new seconds-since-midnight value; used only when load=1.
inc_hour  input  1  one-cycle pulse: hour+1 mod 24; minutes and seconds unchanged.
inc_min  input  1  one-cycle pulse: minute+1 mod 60; no carry into hour; seconds unchanged.
sec_tick  output  1  one-cycle pulse on each second boundary.
cur_sec  output  17  seconds since midnight.
hour  output  5  0..23.
minute  output  6  0..59.
second  output  6  0..59.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0: prescaler=0, cur_sec=0, hour=minute=second=0, sec_tick=0. Reset overrides every other input.
- Prescaler:
  - When run=1, it counts 0..CLK_HZ-1.
  - On the cycle it is at CLK_HZ-1 it returns to 0, and in that same cycle the time advances and sec_tick=1, registered.
  - When run=0 the prescaler holds and sec_tick stays 0.
- Advance: second+1. At 59 it wraps to 0 and carries into minute; minute 59 carries into hour; hour 23 wraps to 0. cur_sec+1, and DAY_SEC-1 wraps to 0.
- The outputs always satisfy cur_sec = hour*3600 + minute*60 + second.
  - All four are registered and updated on the same edge. No output lags another by a cycle.
  - Either both representations are kept in step, or the fields are derived combinationally and then registered.
- load:
  - If load_sec >= DAY_SEC, the value is reduced to load_sec - DAY_SEC. Values 86400..131071 always fall in range after one subtraction.
  - hour, minute and second are recomputed from the loaded value, and the results are visible on the next edge.
  - The prescaler is cleared to 0, so a full second elapses before the next sec_tick.
- inc_hour / inc_min: adjust the field, recompute cur_sec by ±3600 / ±60 with wrap, and leave the prescaler untouched.
- Priority when events coincide in one cycle: rst_n=0 > load > inc_hour > inc_min > tick advance.
  - The winning event alone updates the time. Lower-priority events that cycle are dropped.
  - Exception: a coincident tick still clears the prescaler and raises sec_tick, but the tick's advance is lost.
- Pulses that last more than one cycle act once per cycle. The input stage is responsible for single-cycle pulses.
- sec_tick is never asserted during reset or on the first cycle after rst_n rises.

Test Plan:
1. Use CLK_HZ=4 in the bench. Release reset with run=1 → sec_tick on every 4th cycle; first tick 4 cycles after release; cur_sec 0→1→2; second follows.
2. load=1 with load_sec=86399, run=1 → hour=23, minute=59, second=59 next edge; after one tick cur_sec=0 and all fields 0, with no glitch value in between.
3. load_sec=90000 → cur_sec=3600 and hour=1; load_sec=131071 → cur_sec=44671, hour=12, minute=24, second=31.
4. Time 23:59:30: inc_hour → 00:59:30, cur_sec=3570; then inc_min at minute 59 → 00:00:30, hour unchanged.
5. load and inc_min asserted in the same cycle as the prescaler terminal count → loaded value wins; sec_tick=1; prescaler=0; the next tick comes 4 cycles later.
6. run=0 for 10 cycles mid-second, then run=1 → no ticks while paused; the remaining count resumes where it stopped. rst_n=0 mid-count → all outputs 0 on the next edge.
